// File: rtl/hqb_col_norm_pkg.sv
// Shared constants for the column-norm block: default widths, entry count
// and FSM state encoding.
package hqb_col_norm_pkg;

  localparam int DW_DEF    = 16;
  localparam int FRAC_DEF  = 8;
  localparam int N_ENTRIES = 8;
  localparam int IDX_W     = $clog2(N_ENTRIES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/hqb_col_norm_cmag2.sv
// Squared magnitude of one complex entry: re^2 + im^2, purely combinational.
// The sum of two full-width squares can reach 2^(2*DW-1), so one carry bit is kept.
module hqb_col_norm_cmag2 #(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic        [2*DW:0] o_mag2
);

  logic signed [2*DW-1:0] w_re_x;
  logic signed [2*DW-1:0] w_im_x;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;

  assign w_re_x  = {{DW{i_re[DW-1]}}, i_re};
  assign w_im_x  = {{DW{i_im[DW-1]}}, i_im};
  assign w_re_sq = w_re_x * w_re_x;
  assign w_im_sq = w_im_x * w_im_x;

  // Squares are never negative, so zero-extension before the add is exact.
  assign o_mag2 = {1'b0, w_re_sq} + {1'b0, w_im_sq};

endmodule

// File: rtl/hqb_col_norm.sv
// Squared Frobenius norm of a captured 4x2 complex column pair, one entry per
// cycle, with edge-triggered start, sticky overrun flag and a one-cycle result strobe.
module hqb_col_norm
  import hqb_col_norm_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4*DW-1:0]   col0_r,
  input  logic [4*DW-1:0]   col0_i,
  input  logic [4*DW-1:0]   col1_r,
  input  logic [4*DW-1:0]   col1_i,
  output logic              in_ready,
  output logic              busy,
  output logic [2*DW+3:0]   norm_out,
  output logic              norm_valid,
  output logic              overrun
);

  localparam int ACC_W = 2*DW + 4;

  if (FRAC >= DW) begin : g_bad_frac
    $error("hqb_col_norm: FRAC must be smaller than DW");
  end

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_norm;
  logic             r_norm_valid;
  logic             r_overrun;
  logic             r_in_valid_d;
  logic [4*DW-1:0]  r_col0_r;
  logic [4*DW-1:0]  r_col0_i;
  logic [4*DW-1:0]  r_col1_r;
  logic [4*DW-1:0]  r_col1_i;

  logic             w_start;
  logic             w_accept;
  logic [1:0]       w_lane;
  logic signed [DW-1:0] w_re;
  logic signed [DW-1:0] w_im;
  logic [2*DW:0]    w_mag2;

  assign w_start  = in_valid & ~r_in_valid_d;
  assign w_accept = w_start && (r_state == ST_IDLE);
  assign w_lane   = r_idx[1:0];

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_re = '0;
    w_im = '0;
    if (r_idx[2]) begin
      w_re = r_col1_r[int'(w_lane)*DW +: DW];
      w_im = r_col1_i[int'(w_lane)*DW +: DW];
    end else begin
      w_re = r_col0_r[int'(w_lane)*DW +: DW];
      w_im = r_col0_i[int'(w_lane)*DW +: DW];
    end
  end

  hqb_col_norm_cmag2 #(.DW(DW)) u_cmag2 (
    .i_re   (w_re),
    .i_im   (w_im),
    .o_mag2 (w_mag2)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_norm       <= '0;
      r_norm_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_in_valid_d <= 1'b0;
    end else begin
      r_in_valid_d <= in_valid;
      r_norm_valid <= 1'b0;
      if (w_start && (r_state != ST_IDLE))
        r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_ACC;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        ST_ACC: begin
          r_acc <= r_acc + {{(ACC_W-2*DW-1){1'b0}}, w_mag2};
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(N_ENTRIES-1))
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_norm       <= r_acc;
          r_norm_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the captured column data is never read before a capture loads it,
  // so these wide registers carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_col0_r <= col0_r;
      r_col0_i <= col0_i;
      r_col1_r <= col1_r;
      r_col1_i <= col1_i;
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_ACC) || (r_state == ST_DONE);
  assign norm_out   = r_norm;
  assign norm_valid = r_norm_valid;
  assign overrun    = r_overrun;

endmodule
